integer_issue_scheduler: RTL

- Sits in decode stage (DX1), directly downstream of the per-opcode issue LUT.
- Takes each candidate instruction's retiring stage and functional unit, and decides whether it may issue this cycle.
- Keeps a writeback reservation shift register, per-unit initiation-interval counters and in-flight destination tags.
- Stalls issue on three conditions: writeback-port conflict, busy functional unit, or read-after-write hazard.

---
 rtl/integer_issue_scheduler_pkg.sv | 27 ++
 rtl/integer_issue_scheduler_if.sv | 46 ++++
 rtl/integer_issue_scheduler_fu_counter.sv | 44 ++++
 rtl/integer_issue_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/integer_issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// integer_issue_scheduler_pkg : shared DX1 issue-control types and constants
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package integer_issue_scheduler_pkg;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_SM  = 2'd1,
    FU_IMU = 2'd2
  } functional_unit_t;

  localparam int ISSUE_MAX_LATENCY        = 4;
  localparam int ISSUE_STALL_REASON_WIDTH = 3;

  // Bit positions inside stall_reason
  typedef enum int unsigned {
    STALL_WB  = 0,
    STALL_FU  = 1,
    STALL_RAW = 2
  } stall_bit_e;

endpackage

`default_nettype wire

// File: rtl/integer_issue_scheduler_if.sv
// ---------------------------------------------------------------------------
// integer_issue_scheduler_if : DX1 candidate / issue-decision bundle
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface integer_issue_scheduler_if #(
  parameter int NUM_REGISTERS = 8,
  parameter int NUM_SOURCES   = 3
);
  import integer_issue_scheduler_pkg::*;

  localparam int RI = $clog2(NUM_REGISTERS);

  logic                                dx1_valid;
  logic [2:0]                          dx1_retiring_stage;
  functional_unit_t                    dx1_functional_unit;
  logic                                dx1_dst_valid;
  logic [RI-1:0]                       dx1_dst_index;
  logic [NUM_SOURCES-1:0]              dx1_src_valid;
  logic [NUM_SOURCES*RI-1:0]           dx1_src_index;

  logic                                dx1_issue;
  logic                                dx1_stall;
  logic [ISSUE_STALL_REASON_WIDTH-1:0] stall_reason;
  logic                                wb_expected;
  logic [RI-1:0]                       wb_expected_index;
  logic                                latency_error;

  modport master (
    output dx1_valid, dx1_retiring_stage, dx1_functional_unit,
           dx1_dst_valid, dx1_dst_index, dx1_src_valid, dx1_src_index,
    input  dx1_issue, dx1_stall, stall_reason,
           wb_expected, wb_expected_index, latency_error
  );

  modport slave (
    input  dx1_valid, dx1_retiring_stage, dx1_functional_unit,
           dx1_dst_valid, dx1_dst_index, dx1_src_valid, dx1_src_index,
    output dx1_issue, dx1_stall, stall_reason,
           wb_expected, wb_expected_index, latency_error
  );

endinterface

`default_nettype wire

// File: rtl/integer_issue_scheduler_fu_counter.sv
// ---------------------------------------------------------------------------
// integer_issue_fu_counter : saturating initiation-interval counter per unit
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module integer_issue_fu_counter #(
  parameter int INTERVAL = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic busy
);

  localparam int             CW     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0]  RELOAD = CW'(INTERVAL - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // A fresh issue reloads even if the counter is expiring this same cycle
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != '0);

endmodule

`default_nettype wire

// File: rtl/integer_issue_scheduler.sv
// ---------------------------------------------------------------------------
// integer_issue_scheduler : DX1 issue gate for WB-port, FU-busy and RAW stalls
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module integer_issue_scheduler
  import integer_issue_scheduler_pkg::*;
#(
  parameter int MAX_LATENCY   = ISSUE_MAX_LATENCY,
  parameter int NUM_REGISTERS = 8,
  parameter int NUM_SOURCES   = 3,
  parameter int SM_INTERVAL   = 2,
  parameter int IMU_INTERVAL  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  integer_issue_scheduler_if.slave  bus
);

  localparam int RI = $clog2(NUM_REGISTERS);

  // Slot i holds a writeback landing i cycles from now
  logic [MAX_LATENCY:1]          r_q,  r_d;
  logic [MAX_LATENCY:1]          dv_q, dv_d;
  logic [MAX_LATENCY:1][RI-1:0]  d_q,  d_d;
  logic                          wb_expected_q,       wb_expected_d;
  logic [RI-1:0]                 wb_expected_index_q, wb_expected_index_d;
  logic                          latency_error_q,     latency_error_d;

  int                            le;
  logic                          lat_bad;
  logic [MAX_LATENCY:1]          slot_hit;
  logic                          wb_conflict;
  logic                          fu_busy;
  logic                          raw;
  logic                          issue;
  logic                          sm_busy;
  logic                          imu_busy;
  logic [ISSUE_STALL_REASON_WIDTH-1:0] stall_reason;
  logic [RI-1:0]                 src_idx [NUM_SOURCES];

  for (genvar s = 0; s < NUM_SOURCES; s++) begin : g_src_unpack
    assign src_idx[s] = bus.dx1_src_index[s*RI +: RI];
  end

  always_comb begin
    le      = int'(bus.dx1_retiring_stage);
    lat_bad = 1'b0;
    if (bus.dx1_retiring_stage == 3'd0) begin
      le      = 1;
      lat_bad = 1'b1;
    end else if (le > MAX_LATENCY) begin
      le      = MAX_LATENCY;
      lat_bad = 1'b1;
    end
  end

  // Slot 1 is excluded from RAW: that result reaches DX1 via the forward path
  always_comb begin
    slot_hit    = '0;
    wb_conflict = 1'b0;
    raw         = 1'b0;
    for (int i = 1; i <= MAX_LATENCY; i++) begin
      slot_hit[i] = (le == i);
      if (r_q[i] && slot_hit[i]) begin
        wb_conflict = 1'b1;
      end
      if (i >= 2 && r_q[i] && dv_q[i]) begin
        for (int s = 0; s < NUM_SOURCES; s++) begin
          if (bus.dx1_src_valid[s] && (src_idx[s] == d_q[i])) begin
            raw = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    case (bus.dx1_functional_unit)
      FU_SM:   fu_busy = sm_busy;
      FU_IMU:  fu_busy = imu_busy;
      default: fu_busy = 1'b0;
    endcase
  end

  assign issue = bus.dx1_valid & ~wb_conflict & ~fu_busy & ~raw;

  always_comb begin
    stall_reason            = '0;
    stall_reason[STALL_WB]  = wb_conflict;
    stall_reason[STALL_FU]  = fu_busy;
    stall_reason[STALL_RAW] = raw;
    if (!bus.dx1_valid) begin
      stall_reason = '0;
    end
  end

  // The window shifts every cycle; a grant lands in slot Le-1 (or slot 0 for Le==1)
  always_comb begin
    r_d  = (r_q >> 1) | ({MAX_LATENCY{issue}} & (slot_hit >> 1));
    dv_d = dv_q >> 1;
    d_d  = d_q >> RI;
    for (int i = 1; i < MAX_LATENCY; i++) begin
      if (issue && (le == i + 1)) begin
        dv_d[i] = bus.dx1_dst_valid;
        d_d[i]  = bus.dx1_dst_index;
      end
    end
    wb_expected_d       = r_q[1] | (issue & slot_hit[1]);
    wb_expected_index_d = (issue && slot_hit[1]) ? bus.dx1_dst_index : d_q[1];
    latency_error_d     = latency_error_q | (bus.dx1_valid & lat_bad);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q                 <= '0;
      dv_q                <= '0;
      d_q                 <= '0;
      wb_expected_q       <= 1'b0;
      wb_expected_index_q <= '0;
      latency_error_q     <= 1'b0;
    end else begin
      r_q                 <= r_d;
      dv_q                <= dv_d;
      d_q                 <= d_d;
      wb_expected_q       <= wb_expected_d;
      wb_expected_index_q <= wb_expected_index_d;
      latency_error_q     <= latency_error_d;
    end
  end

  integer_issue_fu_counter #(
    .INTERVAL (SM_INTERVAL)
  ) u_sm_counter (
    .clock (clock),
    .reset (reset),
    .load  (issue && (bus.dx1_functional_unit == FU_SM)),
    .busy  (sm_busy)
  );

  integer_issue_fu_counter #(
    .INTERVAL (IMU_INTERVAL)
  ) u_imu_counter (
    .clock (clock),
    .reset (reset),
    .load  (issue && (bus.dx1_functional_unit == FU_IMU)),
    .busy  (imu_busy)
  );

  assign bus.dx1_issue         = issue;
  assign bus.dx1_stall         = bus.dx1_valid & ~issue;
  assign bus.stall_reason      = stall_reason;
  assign bus.wb_expected       = wb_expected_q;
  assign bus.wb_expected_index = wb_expected_index_q;
  assign bus.latency_error     = latency_error_q;

endmodule

`default_nettype wire
